// File: rtl/stream_pkg.sv
// Shared types and constants for the two-input packet stream multiplexer.
package stream_pkg;

    // Arbitration state: free to pick a source, or locked to one until its last beat.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOCK0 = 2'b01,
        LOCK1 = 2'b10
    } state_t;

    // Channel identifiers, also used as the out_src encoding.
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage : stream_pkg

// File: rtl/rr_arb2.sv
// Combinational two-request arbiter with packet lock.
// In IDLE a lone requester wins; on contention the prio channel wins.
// In LOCK0/LOCK1 the locked channel is granted regardless of requests, so a
// packet with an input bubble keeps the output channel.
module rr_arb2
    import stream_pkg::*;
(
    input  logic   i_req0,
    input  logic   i_req1,
    input  logic   i_prio,
    input  state_t i_state,
    output logic   o_gnt_vld,
    output logic   o_gnt
);

    // Grant selection from lock state, requests and priority.
    always_comb begin
        // NOTE: defaults assigned first so every path drives both outputs and no latch is inferred.
        o_gnt_vld = 1'b0;
        o_gnt     = CH0;
        case (i_state)
            IDLE: begin
                if (i_req0 && i_req1) begin
                    o_gnt_vld = 1'b1;
                    o_gnt     = i_prio;
                end else if (i_req0) begin
                    o_gnt_vld = 1'b1;
                    o_gnt     = CH0;
                end else if (i_req1) begin
                    o_gnt_vld = 1'b1;
                    o_gnt     = CH1;
                end
            end
            LOCK0: begin
                o_gnt_vld = 1'b1;
                o_gnt     = CH0;
            end
            LOCK1: begin
                o_gnt_vld = 1'b1;
                o_gnt     = CH1;
            end
            default: begin
                o_gnt_vld = 1'b0;
                o_gnt     = CH0;
            end
        endcase
    end

endmodule : rr_arb2

// File: rtl/stream_mux2_rr.sv
// Two-to-one valid/ready packet multiplexer with per-packet round-robin.
// A single registered output stage gives one cycle of latency and one beat
// per cycle throughput; the slot reloads in the same cycle it drains.
module stream_mux2_rr
    import stream_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in0_valid,
    output logic          in0_ready,
    input  logic [DW-1:0] in0_data,
    input  logic          in0_last,
    input  logic          in1_valid,
    output logic          in1_ready,
    input  logic [DW-1:0] in1_data,
    input  logic          in1_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          out_src
);

    state_t        r_state;
    logic          r_prio;
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic          r_out_last;
    logic          r_out_src;

    logic          w_can_load;
    logic          w_gnt_vld;
    logic          w_gnt;
    logic          w_acc0;
    logic          w_acc1;
    logic          w_acc;
    logic          w_acc_src;
    logic [DW-1:0] w_acc_data;
    logic          w_acc_last;

    rr_arb2 u_arb (
        .i_req0    (in0_valid),
        .i_req1    (in1_valid),
        .i_prio    (r_prio),
        .i_state   (r_state),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt     (w_gnt)
    );

    // The output slot is free when empty or when its beat leaves this cycle.
    assign w_can_load = !r_out_valid || out_ready;

    assign in0_ready  = w_gnt_vld && (w_gnt == CH0) && w_can_load;
    assign in1_ready  = w_gnt_vld && (w_gnt == CH1) && w_can_load;

    // At most one ready is high, so the two accepts are mutually exclusive.
    assign w_acc0     = in0_valid && in0_ready;
    assign w_acc1     = in1_valid && in1_ready;
    assign w_acc      = w_acc0 || w_acc1;
    assign w_acc_src  = w_acc1 ? CH1 : CH0;
    assign w_acc_data = w_acc1 ? in1_data : in0_data;
    assign w_acc_last = w_acc1 ? in1_last : in0_last;

    // Output register: load on accept, clear valid on drain, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all state; the asynchronous reset also discards any held beat.
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= CH0;
        end else if (w_acc) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_acc_data;
            r_out_last  <= w_acc_last;
            r_out_src   <= w_acc_src;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Packet lock FSM; priority moves to the other channel only at packet end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_prio  <= CH0;
        end else if (w_acc) begin
            if (w_acc_last) begin
                r_state <= IDLE;
                r_prio  <= !w_acc_src;
            end else begin
                r_state <= (w_acc_src == CH1) ? LOCK1 : LOCK0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;

endmodule : stream_mux2_rr

// File: tb/tb_stream_mux2_rr.sv
// Scoreboard bench for stream_mux2_rr: a packet-level reference model decides
// grants and readies from the arbitration rules, pushes every accepted beat
// into an expected queue, and a separate monitor compares the output stage.
module tb_stream_mux2_rr;

    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            gap;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          src;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in0_valid, in0_ready, in0_last;
    logic [DW-1:0] in0_data;
    logic          in1_valid, in1_ready, in1_last;
    logic [DW-1:0] in1_data;
    logic          out_valid, out_ready, out_last, out_src;
    logic [DW-1:0] out_data;

    int checks = 0;
    int errors = 0;

    // Stimulus state per channel
    logic          tb_v [2];
    logic [DW-1:0] tb_d [2];
    logic          tb_l [2];
    beat_t         src_q [2][$];
    beat_t         cur [2];
    bit            have [2];
    int            wcnt [2];
    bit            acc [2];
    int            stall = 0;
    int unsigned   ready_pct = 100;

    // Reference model state
    exp_t sbq [$];
    int   lock = -1;
    bit   prio = 1'b0;

    assign in0_valid = tb_v[0];
    assign in0_data  = tb_d[0];
    assign in0_last  = tb_l[0];
    assign in1_valid = tb_v[1];
    assign in1_data  = tb_d[1];
    assign in1_last  = tb_l[1];

    stream_mux2_rr #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: output valid must track the expected queue; the head must be shown stably.
    always @(negedge clk) begin
        #3;
        if (rst_n === 1'b1) begin
            check("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
            if (out_valid === 1'b1 && sbq.size() != 0) begin
                check("out_data", 32'(out_data), 32'(sbq[0].data));
                check("out_last", 32'(out_last), 32'(sbq[0].last));
                check("out_src",  32'(out_src),  32'(sbq[0].src));
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    task automatic push_beat(input int ch, input logic [DW-1:0] d, input logic l, input int gap);
        beat_t b;
        b.data = d;
        b.last = l;
        b.gap  = gap;
        src_q[ch].push_back(b);
    endtask

    // Present new beats (holding any beat that was offered but not taken) and out_ready.
    task automatic drive();
        if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
        end else begin
            out_ready = ($urandom_range(99) < ready_pct);
        end
        for (int k = 0; k < 2; k++) begin
            if (!(tb_v[k] && !acc[k])) begin
                tb_v[k] = 1'b0;
                if (!have[k] && src_q[k].size() != 0) begin
                    cur[k]  = src_q[k].pop_front();
                    have[k] = 1'b1;
                    wcnt[k] = cur[k].gap;
                end
                if (have[k]) begin
                    if (wcnt[k] > 0) begin
                        wcnt[k]--;
                    end else begin
                        tb_v[k] = 1'b1;
                        tb_d[k] = cur[k].data;
                        tb_l[k] = cur[k].last;
                        have[k] = 1'b0;
                    end
                end
            end
            acc[k] = 1'b0;
        end
    endtask

    // Reference model: decide the grant from the rules, check readies, record accepts.
    task automatic model_step();
        bit can_load;
        int g;
        bit er [2];
        can_load = (sbq.size() == 0) || out_ready;
        if (lock >= 0)              g = lock;
        else if (tb_v[0] && tb_v[1]) g = int'(prio);
        else if (tb_v[0])           g = 0;
        else if (tb_v[1])           g = 1;
        else                        g = -1;
        er[0] = (g == 0) && can_load;
        er[1] = (g == 1) && can_load;
        check("in0_ready", 32'(in0_ready), 32'(er[0]));
        check("in1_ready", 32'(in1_ready), 32'(er[1]));
        for (int k = 0; k < 2; k++) begin
            if (tb_v[k] && er[k]) begin
                exp_t e;
                e.data = tb_d[k];
                e.last = tb_l[k];
                e.src  = 1'(k);
                sbq.push_back(e);
                acc[k] = 1'b1;
                if (tb_l[k]) begin
                    lock = -1;
                    prio = (k == 0);
                end else begin
                    lock = k;
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #4;
        model_step();
    endtask

    function automatic bit all_done();
        for (int k = 0; k < 2; k++) begin
            if (src_q[k].size() != 0 || have[k] || (tb_v[k] && !acc[k])) return 1'b0;
        end
        return sbq.size() == 0;
    endfunction

    task automatic run_test(input string nm, input int budget, input int stall_at, input int stall_len);
        int c = 0;
        while (1) begin
            if (c == stall_at) stall = stall_len;
            cycle();
            c++;
            if (all_done()) break;
            if (c >= budget) begin
                checks++;
                errors++;
                $display("FAIL %s timeout actual=%0d cycles required<%0d", nm, c, budget);
                break;
            end
        end
    endtask

    task automatic check_out_zero(input string nm);
        check({nm, "_out_valid"}, 32'(out_valid), 32'd0);
        check({nm, "_out_data"},  32'(out_data),  32'd0);
        check({nm, "_out_last"},  32'(out_last),  32'd0);
        check({nm, "_out_src"},   32'(out_src),   32'd0);
    endtask

    task automatic load_contention(input logic [DW-1:0] base0, input logic [DW-1:0] base1);
        for (int i = 0; i < 4; i++) begin
            push_beat(0, base0 + DW'(i), 1'b1, 0);
            push_beat(1, base1 + DW'(i), 1'b1, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=time_expired required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tb_v[k] = 1'b0; tb_d[k] = '0; tb_l[k] = 1'b0;
            have[k] = 1'b0; acc[k] = 1'b0; wcnt[k] = 0;
        end
        #12;
        check_out_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single-source stream, three beats back to back
        ready_pct = 100;
        push_beat(0, 8'h11, 1'b0, 0);
        push_beat(0, 8'h22, 1'b0, 0);
        push_beat(0, 8'h33, 1'b1, 0);
        run_test("single_src", 50, -1, 0);

        // Contention with single-beat packets: sources must alternate
        load_contention(8'hA0, 8'hB0);
        run_test("contention", 50, -1, 0);

        // Packet lock: in1 waits behind a 3-beat in0 packet
        push_beat(0, 8'h40, 1'b0, 0);
        push_beat(0, 8'h41, 1'b0, 0);
        push_beat(0, 8'h42, 1'b1, 0);
        push_beat(1, 8'h50, 1'b1, 1);
        run_test("lock", 50, -1, 0);

        // Backpressure: 0x5C held for three stalled cycles, then drain and reload together
        push_beat(0, 8'h5C, 1'b1, 0);
        push_beat(0, 8'h5D, 1'b1, 0);
        push_beat(0, 8'h5E, 1'b1, 0);
        run_test("backpressure", 50, 1, 3);

        // In-packet bubble: in1 keeps the lock while it idles and in0 waits
        push_beat(1, 8'h60, 1'b0, 0);
        push_beat(1, 8'h61, 1'b1, 2);
        push_beat(0, 8'h70, 1'b1, 1);
        run_test("bubble", 50, -1, 0);

        // Randomized packets, gaps and backpressure
        ready_pct = 70;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 120; p++) begin
                int len = int'($urandom_range(4, 1));
                for (int b = 0; b < len; b++) begin
                    int gap = ($urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : 0;
                    push_beat(k, DW'($urandom), (b == len - 1), gap);
                end
            end
        end
        run_test("random", 20000, -1, 0);

        // Reset mid-packet with a held beat; leave prio pointing at channel 1 beforehand
        ready_pct = 100;
        push_beat(0, 8'hE0, 1'b1, 0);
        push_beat(1, 8'hE1, 1'b0, 1);
        push_beat(1, 8'hE2, 1'b0, 0);
        push_beat(1, 8'hE3, 1'b0, 0);
        push_beat(1, 8'hE4, 1'b1, 0);
        for (int i = 0; i < 3; i++) cycle();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_out_zero("midreset");
        for (int k = 0; k < 2; k++) begin
            tb_v[k] = 1'b0; have[k] = 1'b0; acc[k] = 1'b0; wcnt[k] = 0;
            src_q[k].delete();
        end
        sbq.delete();
        lock  = -1;
        prio  = 1'b0;
        stall = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First contention after reset must favour channel 0
        load_contention(8'hC0, 8'hD0);
        run_test("post_reset", 50, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_stream_mux2_rr

// File: doc/stream_mux2_rr.md
Name: stream_mux2_rr

Overview:
- Merges two valid/ready packet streams into one output stream.
- Uses round-robin arbitration at packet granularity, so packets are never interleaved.
- Serves as the combining counterpart to the 1-to-2 demultiplexer: it recombines streams that were split upstream onto a shared output channel.
- Has a single registered output stage, giving 1-cycle latency and full throughput of 1 beat/cycle.

Parameters:
- DW, 8, data width of each beat in bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in0_valid  input  1  channel 0 beat valid
- in0_ready  output  1  channel 0 beat accepted this cycle (when valid)
- in0_data  input  DW  channel 0 beat data
- in0_last  input  1  channel 0 final beat of packet
- in1_valid  input  1  channel 1 beat valid
- in1_ready  output  1  channel 1 beat accepted this cycle (when valid)
- in1_data  input  DW  channel 1 beat data
- in1_last  input  1  channel 1 final beat of packet
- out_valid  output  1  output beat valid (registered)
- out_ready  input  1  downstream accepts beat
- out_data  output  DW  output beat data (registered)
- out_last  output  1  output final beat of packet (registered)
- out_src  output  1  source channel of the current output beat (registered)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_src=0
  - state=IDLE, prio=0 (channel 0 favoured first)
- Reset mid-packet: the lock is dropped, any held beat is discarded, and arbitration restarts from IDLE.
- Output register slot:
  - can_load = !out_valid || out_ready (the register is free, or is being drained this cycle).
- Grant, combinational:
  - IDLE: if exactly one inX_valid=1, that channel is granted. If both are valid, channel prio is granted. If neither is valid, no grant.
  - LOCK0 grants channel 0 only. LOCK1 grants channel 1 only, even if the other channel is valid.
- Ready:
  - inK_ready = (grant==K) && can_load.
  - Ready may depend combinationally on out_ready and the valids.
  - The non-granted channel's ready is 0.
- Accept:
  - A beat is accepted when inK_valid && inK_ready.
  - On accept, the output register loads data/last/src=K and out_valid becomes 1 next cycle.
  - If out_ready=1 and there is no accept, out_valid becomes 0 next cycle.
  - If out_ready=0 and out_valid=1, the output register holds all fields stable.
- State machine (states IDLE, LOCK0, LOCK1):
  - IDLE -> LOCKK: on accepting a beat from K with last=0.
  - IDLE stays IDLE: on accepting a beat from K with last=1 (single-beat packet); prio <= !K.
  - LOCKK -> IDLE: on accepting a beat from K with last=1; prio <= !K.
  - LOCKK stays LOCKK: on accepting a beat with last=0, or when there is no accept (input bubbles are allowed inside a packet).
- prio updates only at packet end. Arbitration is therefore fair per packet, not per beat.
- Latency: an accepted beat appears at the output on the next rising edge.
- Throughput: back-to-back beats every cycle while out_ready=1.
- Arbitration is work-conserving: if only one channel is valid, it is granted regardless of prio.
- Inputs must hold data stable while valid && !ready; the block does not check this.

Decomposition:
- Shared package stream_pkg:
  - state enum with encodings IDLE=2'b00, LOCK0=2'b01, LOCK1=2'b10
  - localparam CH0=1'b0, CH1=1'b1
- Sub-module: rr_arb2, a combinational 2-request grant from requests, prio, and lock state.
- The output register and FSM live in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-packet with out_valid=1 -> out_valid, out_data, out_last and out_src all read 0 immediately (asynchronous). After release, state is IDLE and the first contention grants channel 0.
- Single-source stream, out_ready=1: in0 sends 0x11, 0x22, 0x33 (last on 0x33) on consecutive cycles -> out_data 0x11, 0x22, 0x33 appears one cycle later each, with out_src=0 and out_last only on 0x33.
- Contention with single-beat packets: both channels valid every cycle, all last=1, in0 data 0xA0.., in1 data 0xB0.. -> out_src alternates 0,1,0,1 and the first output is 0xA0.
- Packet lock: in0 sends a 3-beat packet while in1 is valid from cycle 1 -> in1_ready stays 0 until in0's last beat is accepted. in1's beat follows immediately, and no interleaving occurs.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 and out_data=0x5C -> out_data holds 0x5C and in0_ready=in1_ready=0. When out_ready returns to 1, the next beat loads in the same cycle as the drain, with no bubble.
- In-packet bubble: in1 packet beat 1 accepted, then in1_valid=0 for 2 cycles while in0_valid=1 -> in0 is not granted. The lock holds until in1 delivers its last beat.
